// File: rtl/fft_sdf_r2_stage16_if.sv
// +------------------------------------------------------------------+
// | fft_sdf_r2_stage16_if : sample/twiddle bundle for the SDF stage  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

interface fft_sdf_r2_stage16_if #(
  parameter int DW = 24
);
  logic                 in_valid;
  logic signed [DW-1:0] din_r;
  logic signed [DW-1:0] din_i;
  logic [1:0]           state;
  logic signed [DW-1:0] w_r;
  logic signed [DW-1:0] w_i;
  logic                 out_valid;
  logic signed [DW-1:0] dout_r;
  logic signed [DW-1:0] dout_i;

  modport master (
    output in_valid, din_r, din_i, state, w_r, w_i,
    input  out_valid, dout_r, dout_i
  );

  modport slave (
    input  in_valid, din_r, din_i, state, w_r, w_i,
    output out_valid, dout_r, dout_i
  );
endinterface

`default_nettype wire

// File: rtl/fft_sdf_r2_stage16.sv
// +------------------------------------------------------------------+
// | fft_sdf_r2_stage16 : radix-2 SDF butterfly/twiddle stage, span 16 |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module fft_sdf_r2_stage16 #(
  parameter int DEPTH = 16,
  parameter int DW    = 24,
  parameter int FRAC  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  fft_sdf_r2_stage16_if.slave bus
);

  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_BFLY = 2'd1;
  localparam logic [1:0] ST_TWID = 2'd2;
  localparam int         PW      = 2 * DW;
  localparam int         TW      = 2 * DW + 1;

  logic signed [DW-1:0] dly_r_q [DEPTH];
  logic signed [DW-1:0] dly_i_q [DEPTH];
  logic signed [DW-1:0] dly_r_d [DEPTH];
  logic signed [DW-1:0] dly_i_d [DEPTH];

  logic                 out_valid_q, out_valid_d;
  logic signed [DW-1:0] dout_r_q, dout_r_d;
  logic signed [DW-1:0] dout_i_q, dout_i_d;

  logic signed [DW-1:0] x_r, x_i;
  logic signed [DW-1:0] a_r, a_i;
  logic signed [DW-1:0] push_r, push_i;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [TW-1:0] t_r, t_i;
  logic                 shift_en;
  logic                 unused_bits;

  always_comb begin
    x_r = bus.in_valid ? bus.din_r : '0;
    x_i = bus.in_valid ? bus.din_i : '0;
    a_r = dly_r_q[0];
    a_i = dly_i_q[0];

    // Full-precision complex multiply of the head entry by the twiddle
    p_rr = PW'(a_r) * PW'(bus.w_r);
    p_ii = PW'(a_i) * PW'(bus.w_i);
    p_ri = PW'(a_r) * PW'(bus.w_i);
    p_ir = PW'(a_i) * PW'(bus.w_r);
    t_r  = TW'(p_rr) - TW'(p_ii);
    t_i  = TW'(p_ri) + TW'(p_ir);

    shift_en    = bus.in_valid || (bus.state != ST_FILL);
    push_r      = x_r;
    push_i      = x_i;
    out_valid_d = 1'b0;
    dout_r_d    = dout_r_q;
    dout_i_d    = dout_i_q;

    case (bus.state)
      ST_BFLY: begin
        push_r      = a_r - x_r;
        push_i      = a_i - x_i;
        out_valid_d = 1'b1;
        dout_r_d    = a_r + x_r;
        dout_i_d    = a_i + x_i;
      end
      ST_TWID: begin
        // Bit slice at FRAC equals the arithmetic shift followed by DW-bit truncation
        out_valid_d = 1'b1;
        dout_r_d    = t_r[FRAC +: DW];
        dout_i_d    = t_i[FRAC +: DW];
      end
      default: ;
    endcase

    for (int k = 0; k < DEPTH - 1; k++) begin
      dly_r_d[k] = shift_en ? dly_r_q[k+1] : dly_r_q[k];
      dly_i_d[k] = shift_en ? dly_i_q[k+1] : dly_i_q[k];
    end
    dly_r_d[DEPTH-1] = shift_en ? push_r : dly_r_q[DEPTH-1];
    dly_i_d[DEPTH-1] = shift_en ? push_i : dly_i_q[DEPTH-1];
  end

  assign unused_bits = ^{t_r[TW-1:FRAC+DW], t_r[FRAC-1:0],
                         t_i[TW-1:FRAC+DW], t_i[FRAC-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      dout_r_q    <= '0;
      dout_i_q    <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        dly_r_q[k] <= '0;
        dly_i_q[k] <= '0;
      end
    end else begin
      out_valid_q <= out_valid_d;
      dout_r_q    <= dout_r_d;
      dout_i_q    <= dout_i_d;
      for (int k = 0; k < DEPTH; k++) begin
        dly_r_q[k] <= dly_r_d[k];
        dly_i_q[k] <= dly_i_d[k];
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.dout_r    = dout_r_q;
  assign bus.dout_i    = dout_i_q;

endmodule

`default_nettype wire

// File: tb/tb_fft_sdf_r2_stage16.sv
// +------------------------------------------------------------------+
// | tb_fft_sdf_r2_stage16 : directed scoreboard bench for SDF stage  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_fft_sdf_r2_stage16;

  localparam int DW = 24;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic quiet = 1'b0;
  logic end_req = 1'b0;

  int checks   = 0;
  int failures = 0;

  logic [2*DW-1:0] expq [$];

  fft_sdf_r2_stage16_if #(.DW(DW)) bus ();

  fft_sdf_r2_stage16 #(.DEPTH(16), .DW(DW), .FRAC(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic drive(input int v, input int dr, input int di,
                       input int st, input int wr, input int wi);
    bus.in_valid = v[0];
    bus.din_r    = DW'(dr);
    bus.din_i    = DW'(di);
    bus.state    = st[1:0];
    bus.w_r      = DW'(wr);
    bus.w_i      = DW'(wi);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input int er, input int ei);
    expq.push_back({DW'(er), DW'(ei)});
  endtask

  task automatic idle_and_reset();
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic dc_frame();
    for (int i = 0; i < 16; i++) drive(1, 256, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      expect_out(512, 0);
      drive(1, 256, 0, 1, 0, 0);
    end
    for (int i = 0; i < 16; i++) begin
      expect_out(0, 0);
      drive(1, 256, 0, 2, 256, 0);
    end
  endtask

  // Monitor: sole owner of the counters; reacts to clock and to reset assertion
  always begin
    logic [2*DW-1:0] e;
    @(negedge clk or negedge rst_n);
    #1;
    if (!rst_n) begin
      checks++;
      if (bus.out_valid !== 1'b0 || bus.dout_r !== '0 || bus.dout_i !== '0) begin
        failures++;
        $display("FAIL reset_outputs got valid=%0b dout=(%0d,%0d) exp valid=0 dout=(0,0)",
                 bus.out_valid, bus.dout_r, bus.dout_i);
      end
      checks++;
      if (expq.size() != 0) begin
        failures++;
        $display("FAIL pending_at_reset got %0d outstanding exp 0", expq.size());
      end
      expq.delete();
    end else if (quiet) begin
      checks++;
      if (bus.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL fill_quiet got out_valid=%0b exp 0", bus.out_valid);
      end
    end else if (bus.out_valid === 1'b1) begin
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output got (%0d,%0d) exp no output",
                 bus.dout_r, bus.dout_i);
      end else begin
        e = expq.pop_front();
        if ({bus.dout_r, bus.dout_i} !== e) begin
          failures++;
          $display("FAIL out_data got (%0d,%0d) exp (%0d,%0d)",
                   bus.dout_r, bus.dout_i,
                   $signed(e[2*DW-1:DW]), $signed(e[DW-1:0]));
        end
      end
    end
    if (end_req) begin
      checks++;
      if (expq.size() != 0) begin
        failures++;
        $display("FAIL missing_outputs got %0d never produced exp 0", expq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'($urandom);
      bus.din_r    = DW'($urandom);
      bus.din_i    = DW'($urandom);
      bus.state    = 2'($urandom);
      bus.w_r      = DW'($urandom);
      bus.w_i      = DW'($urandom);
      @(posedge clk);
    end
    #1;
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 16; i++) drive(1, 0, 0, 0, 0, 0);
    quiet = 1'b0;
    idle_and_reset();

    // DC input
    dc_frame();
    idle_and_reset();

    // Impulse at sample 0
    for (int i = 0; i < 16; i++) drive(1, (i == 0) ? 256 : 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      expect_out((i == 0) ? 256 : 0, 0);
      drive(1, 0, 0, 1, 0, 0);
    end
    for (int i = 0; i < 16; i++) begin
      expect_out((i == 0) ? 256 : 0, 0);
      drive(1, 0, 0, 2, 256, 0);
    end
    idle_and_reset();

    // Twiddle: x[20]=256, x[21]=1 (floor rounding), x[22]=256j
    for (int i = 0; i < 16; i++) drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      int xr, xi;
      xr = (i == 4) ? 256 : ((i == 5) ? 1 : 0);
      xi = (i == 6) ? 256 : 0;
      expect_out(xr, xi);
      drive(1, xr, xi, 1, 0, 0);
    end
    for (int i = 0; i < 16; i++) begin
      if (i == 4)      expect_out(-181, 181);
      else if (i == 5) expect_out(-1, 0);
      else if (i == 6) expect_out(-181, -181);
      else             expect_out(0, 0);
      drive(1, 0, 0, 2, 181, -181);
    end
    idle_and_reset();

    // Wrap: 0x7FFFFF + 0x7FFFFF -> 0xFFFFFE, difference 0
    for (int i = 0; i < 16; i++) drive(1, (i == 0) ? 'h7FFFFF : 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      expect_out((i == 0) ? -2 : 0, 0);
      drive(1, (i == 0) ? 'h7FFFFF : 0, 0, 1, 0, 0);
    end
    for (int i = 0; i < 16; i++) begin
      expect_out(0, 0);
      drive(1, 0, 0, 2, 256, 0);
    end
    idle_and_reset();

    // Mid-frame reset during the 8th twiddle cycle
    for (int i = 0; i < 16; i++) drive(1, 256, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      expect_out(512, 0);
      drive(1, 256, 0, 1, 0, 0);
    end
    for (int i = 0; i < 7; i++) begin
      expect_out(0, 0);
      drive(1, 256, 0, 2, 256, 0);
    end
    bus.in_valid = 1'b1;
    bus.din_r    = DW'(256);
    bus.din_i    = '0;
    bus.state    = 2'd2;
    bus.w_r      = DW'(256);
    bus.w_i      = '0;
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reading out the whole line shows it was cleared
    for (int i = 0; i < 16; i++) begin
      expect_out(0, 0);
      drive(0, 0, 0, 1, 0, 0);
    end
    drive(0, 0, 0, 0, 0, 0);
    dc_frame();
    drive(0, 0, 0, 0, 0, 0);

    end_req = 1'b1;
    repeat (4) @(posedge clk);
    $display("FAIL monitor did not finish");
    $fatal(1, "monitor stalled");
  end

endmodule

`default_nettype wire
